// File: rtl/pokey_timer_ctrl_pkg.sv
// rtl/pokey_timer_ctrl_pkg.sv - shared AUDCTL bit indices and channel FSM encodings
package pokey_timer_ctrl_pkg;

  localparam int AC_15K     = 0;
  localparam int AC_J34     = 3;
  localparam int AC_J12     = 4;
  localparam int AC_CH3FAST = 5;
  localparam int AC_CH1FAST = 6;

  localparam int NUM_CH = 4;
  localparam int RCNT_W = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RELOAD = 1'b1
  } chan_state_e;

  // Count source for a channel that is not the high half of a joined pair.
  function automatic logic base_or_fast(input logic fast, input logic base_tick);
    return fast ? 1'b1 : base_tick;
  endfunction

endpackage

// File: rtl/pokey_timer_ctrl_if.sv
// rtl/pokey_timer_ctrl_if.sv - timer-control signal bundle between prescaler/registers and the timers
interface pokey_timer_ctrl_if;

  logic       tick64k;
  logic       tick15k;
  logic [7:0] audctl;
  logic       stimer;
  logic [3:0] nBor;
  logic [3:0] ld;
  logic [3:0] cr;
  logic [3:0] evt;

  modport master (
    output tick64k, tick15k, audctl, stimer, nBor,
    input  ld, cr, evt
  );

  modport slave (
    input  tick64k, tick15k, audctl, stimer, nBor,
    output ld, cr, evt
  );

endinterface

// File: rtl/timer_chan_seq.sv
// rtl/timer_chan_seq.sv - single-channel RUN/RELOAD sequencer with registered ld/cr/evt
module timer_chan_seq
  import pokey_timer_ctrl_pkg::*;
#(
  parameter int unsigned RELOAD_CYC = 1
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic src_i,
  input  logic underflow_i,
  input  logic force_reload_i,
  input  logic joined_low_i,
  input  logic pair_reload_i,
  output logic ld_o,
  output logic cr_o,
  output logic evt_o,
  output logic run_o
);

  localparam logic [RCNT_W-1:0] CNT_INIT = RCNT_W'(RELOAD_CYC - 1);

  chan_state_e       state_q;
  logic [RCNT_W-1:0] cnt_q;
  logic              ld_q;
  logic              cr_q;
  logic              evt_q;
  logic              own_reload;

  // A joined low half wraps through zero on its own; only its partner reloads it.
  assign own_reload = underflow_i && !joined_low_i;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      cr_q    <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      evt_q <= 1'b0;
      if (force_reload_i) begin
        state_q <= ST_RELOAD;
        cnt_q   <= CNT_INIT;
        ld_q    <= 1'b1;
        cr_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (own_reload || pair_reload_i) begin
              state_q <= ST_RELOAD;
              cnt_q   <= CNT_INIT;
              ld_q    <= 1'b1;
              cr_q    <= 1'b0;
              evt_q   <= own_reload;
            end else begin
              cr_q <= src_i;
            end
          end
          ST_RELOAD: begin
            if (cnt_q == '0) begin
              state_q <= ST_RUN;
              ld_q    <= 1'b0;
              cr_q    <= src_i;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_RUN;
            ld_q    <= 1'b0;
            cr_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ld_o  = ld_q;
  assign cr_o  = cr_q;
  assign evt_o = evt_q;
  assign run_o = (state_q == ST_RUN);

endmodule

// File: rtl/pokey_timer_ctrl.sv
// rtl/pokey_timer_ctrl.sv - POKEY timer sequencing: clock select, pair joining, reload/event generation
module pokey_timer_ctrl
  import pokey_timer_ctrl_pkg::*;
#(
  parameter int unsigned RELOAD_CYC = 1
) (
  input  logic               clk,
  input  logic               nRst,
  pokey_timer_ctrl_if.slave  bus
);

  logic              base_tick;
  logic              join12;
  logic              join34;
  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] underflow;
  logic [NUM_CH-1:0] joined_low;
  logic [NUM_CH-1:0] pair_reload;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] ld_w;
  logic [NUM_CH-1:0] cr_w;
  logic [NUM_CH-1:0] evt_w;
  logic              unused_audctl;

  assign base_tick = bus.audctl[AC_15K] ? bus.tick15k : bus.tick64k;
  assign join12    = bus.audctl[AC_J12];
  assign join34    = bus.audctl[AC_J34];
  assign underflow = ~bus.nBor;

  // High half of a joined pair counts on the low half's underflow, seen only while the low half runs.
  assign src[0] = base_or_fast(bus.audctl[AC_CH1FAST], base_tick);
  assign src[1] = join12 ? (run[0] && underflow[0]) : base_tick;
  assign src[2] = base_or_fast(bus.audctl[AC_CH3FAST], base_tick);
  assign src[3] = join34 ? (run[2] && underflow[2]) : base_tick;

  assign joined_low  = {1'b0, join34, 1'b0, join12};
  assign pair_reload = {1'b0, join34 && run[3] && underflow[3],
                        1'b0, join12 && run[1] && underflow[1]};

  assign unused_audctl = ^{bus.audctl[7], bus.audctl[2:1]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    timer_chan_seq #(
      .RELOAD_CYC(RELOAD_CYC)
    ) u_seq (
      .clk_i         (clk),
      .nrst_i        (nRst),
      .src_i         (src[i]),
      .underflow_i   (underflow[i]),
      .force_reload_i(bus.stimer),
      .joined_low_i  (joined_low[i]),
      .pair_reload_i (pair_reload[i]),
      .ld_o          (ld_w[i]),
      .cr_o          (cr_w[i]),
      .evt_o         (evt_w[i]),
      .run_o         (run[i])
    );
  end

  assign bus.ld  = ld_w;
  assign bus.cr  = cr_w;
  assign bus.evt = evt_w;

endmodule

// File: tb/tb_pokey_timer_ctrl.sv
// tb/tb_pokey_timer_ctrl.sv - directed vector bench for pokey_timer_ctrl
module tb_pokey_timer_ctrl;

  typedef struct {
    logic       rst_n;
    logic [7:0] aud;
    logic       t64;
    logic       t15;
    logic       stim;
    logic [3:0] nbor;
    logic [3:0] e_ld;
    logic [3:0] e_cr;
    logic [3:0] e_evt;
  } vec_t;

  logic       clk   = 1'b0;
  logic       nRst  = 1'b0;
  logic       t64   = 1'b0;
  logic       t15   = 1'b0;
  logic       stim  = 1'b0;
  logic [7:0] aud   = 8'h00;
  logic [3:0] nbor  = 4'hF;
  int         n_vec = 0;
  int         n_bad = 0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  pokey_timer_ctrl_if bus_a ();
  pokey_timer_ctrl_if bus_b ();

  assign bus_a.tick64k = t64;
  assign bus_a.tick15k = t15;
  assign bus_a.audctl  = aud;
  assign bus_a.stimer  = stim;
  assign bus_a.nBor    = nbor;
  assign bus_b.tick64k = t64;
  assign bus_b.tick15k = t15;
  assign bus_b.audctl  = aud;
  assign bus_b.stimer  = stim;
  assign bus_b.nBor    = nbor;

  pokey_timer_ctrl #(.RELOAD_CYC(1)) dut_a (.clk(clk), .nRst(nRst), .bus(bus_a));
  pokey_timer_ctrl #(.RELOAD_CYC(4)) dut_b (.clk(clk), .nRst(nRst), .bus(bus_b));

  function automatic void add(input logic r, input logic [7:0] a, input logic f64, input logic f15,
                              input logic s, input logic [3:0] nb, input logic [3:0] l,
                              input logic [3:0] c, input logic [3:0] e);
    vec_t v;
    v.rst_n = r; v.aud = a; v.t64 = f64; v.t15 = f15; v.stim = s;
    v.nbor = nb; v.e_ld = l; v.e_cr = c; v.e_evt = e;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [7:0] a, input logic f64, input logic f15,
                      input logic s, input logic [3:0] nb);
    @(negedge clk);
    nRst = r; aud = a; t64 = f64; t15 = f15; stim = s; nbor = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ld/cr/evt=%03h want %03h", name, act, exp);
    end
  endtask

  initial begin
    //  rst aud    t64 t15 stm nbor   ld    cr    evt
    add(0, 8'h00, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 1, 0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hE, 4'h1, 4'h0, 4'h1);
    add(1, 8'h00, 1, 0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
    add(1, 8'h00, 1, 0, 0, 4'hE, 4'h1, 4'hE, 4'h1);
    add(1, 8'h00, 0, 0, 0, 4'hE, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h41, 1, 0, 0, 4'hF, 4'h0, 4'h1, 4'h0);
    add(1, 8'h41, 0, 1, 0, 4'hF, 4'h0, 4'hF, 4'h0);
    add(1, 8'h41, 1, 1, 0, 4'hF, 4'h0, 4'hF, 4'h0);
    add(1, 8'h41, 0, 0, 0, 4'hF, 4'h0, 4'h1, 4'h0);
    add(1, 8'h10, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h10, 1, 0, 0, 4'hE, 4'h0, 4'hF, 4'h0);
    add(1, 8'h10, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h10, 0, 0, 0, 4'hD, 4'h3, 4'h0, 4'h2);
    add(1, 8'h10, 1, 0, 0, 4'hF, 4'h0, 4'hD, 4'h0);
    add(1, 8'h00, 1, 0, 1, 4'h7, 4'hF, 4'h0, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hB, 4'h4, 4'h0, 4'h4);
    add(0, 8'h00, 1, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 1, 0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
    add(1, 8'h18, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h18, 1, 0, 0, 4'hB, 4'h0, 4'hD, 4'h0);
    add(1, 8'h18, 0, 0, 0, 4'h7, 4'hC, 4'h0, 4'h8);
    add(1, 8'h18, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 8'h00, 1, 0, 0, 4'hF, 4'h0, 4'hF, 4'h0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].aud, vecs[i].t64, vecs[i].t15, vecs[i].stim, vecs[i].nbor);
      chk($sformatf("vec%0d", i), {bus_a.ld, bus_a.cr, bus_a.evt},
          {vecs[i].e_ld, vecs[i].e_cr, vecs[i].e_evt});
    end

    // Four-cycle reload window on ch3; a repeat underflow inside it must be ignored.
    step(0, 8'h00, 0, 0, 0, 4'hF);
    chk("b_reset", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h000);
    step(1, 8'h00, 0, 0, 0, 4'hB);
    chk("b_uf3", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h404);
    for (int k = 1; k <= 3; k++) begin
      step(1, 8'h00, 1, 0, 0, (k == 2) ? 4'hB : 4'hF);
      chk($sformatf("b_win%0d", k), {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h4B0);
    end
    step(1, 8'h00, 1, 0, 0, 4'hF);
    chk("b_exit", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h0F0);
    step(1, 8'h00, 0, 0, 0, 4'hF);
    chk("b_idle", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h000);

    // STIMER mid-window restarts the full count on every channel.
    step(1, 8'h00, 0, 0, 0, 4'hB);
    chk("b_uf3b", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h404);
    step(1, 8'h00, 0, 0, 0, 4'hF);
    chk("b_mid", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h400);
    for (int k = 0; k < 4; k++) begin
      step(1, 8'h00, 0, 0, (k == 0) ? 1'b1 : 1'b0, 4'hF);
      chk($sformatf("b_stim%0d", k), {bus_b.ld, bus_b.cr, bus_b.evt}, 12'hF00);
    end
    step(1, 8'h00, 1, 0, 0, 4'hF);
    chk("b_stim_exit", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h0F0);

    // Reset in the middle of a reload window.
    step(1, 8'h00, 0, 0, 0, 4'hB);
    chk("b_uf3c", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h404);
    step(0, 8'h00, 1, 0, 0, 4'hF);
    chk("b_rst_mid", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h000);
    step(1, 8'h00, 1, 0, 0, 4'hF);
    chk("b_run_after", {bus_b.ld, bus_b.cr, bus_b.evt}, 12'h0F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
